// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared types and BCD helpers for the stopwatch controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } bcd_time_t;

  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;

  // Two-digit BCD increment; callers handle the terminal value themselves.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_time_inc.sv
// ---------------------------------------------------------------------------
// bcd_time_inc : combinational MM:SS.cc BCD incrementer with wrap flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_time_inc import stopwatch_pkg::*; (
  input  bcd_time_t  cur_time,
  input  logic       en,
  input  logic [7:0] max_min,
  output bcd_time_t  next_time,
  output logic       wrap
);

  always_comb begin
    next_time = cur_time;
    wrap      = 1'b0;
    if (en) begin
      if (cur_time.cs == CS_MAX) begin
        next_time.cs = '0;
        if (cur_time.sec == SEC_MAX) begin
          next_time.sec = '0;
          if (cur_time.min == max_min) begin
            next_time.min = '0;
            wrap          = 1'b1;
          end else begin
            next_time.min = bcd_inc(cur_time.min);
          end
        end else begin
          next_time.sec = bcd_inc(cur_time.sec);
        end
      end else begin
        next_time.cs = bcd_inc(cur_time.cs);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl : button-driven run/pause/lap FSM, BCD time and display bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int MAX_MIN = 59
) (
  input  logic       i_sclk,
  input  logic       i_reset,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  input  logic       i_base_tick,
  output logic       o_timerenb,
  output logic       o_timer_rst_n,
  output logic       o_running,
  output logic       o_lap_active,
  output logic [7:0] o_disp_cs,
  output logic [7:0] o_disp_sec,
  output logic [7:0] o_disp_min,
  output logic       o_rollover
);

  localparam logic [7:0] MAX_MIN_BCD = to_bcd(MAX_MIN);

  state_t    state;
  bcd_time_t live_time;
  bcd_time_t lap_time;
  bcd_time_t next_live;
  logic      tq;
  logic      tick;
  logic      counting;
  logic      wrap;

  // Both edges of the timer toggle are 10 ms steps.
  assign tick     = i_base_tick ^ tq;
  assign counting = (state == RUN) || (state == LAP);

  bcd_time_inc u_inc (
    .cur_time  (live_time),
    .en        (counting & tick),
    .max_min   (MAX_MIN_BCD),
    .next_time (next_live),
    .wrap      (wrap)
  );

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      state         <= IDLE;
      live_time     <= '0;
      lap_time      <= '0;
      tq            <= 1'b0;
      o_timerenb    <= 1'b0;
      o_timer_rst_n <= 1'b0;
      o_running     <= 1'b0;
      o_lap_active  <= 1'b0;
      o_rollover    <= 1'b0;
      {o_disp_min, o_disp_sec, o_disp_cs} <= '0;
    end else begin
      tq            <= i_base_tick;
      o_timer_rst_n <= 1'b1;
      o_rollover    <= wrap;
      live_time     <= next_live;
      {o_disp_min, o_disp_sec, o_disp_cs} <= o_lap_active ? lap_time : live_time;

      // Only the highest-priority event is acted on: clear, start_stop, lap.
      if (i_clear) begin
        state         <= IDLE;
        live_time     <= '0;
        lap_time      <= '0;
        o_lap_active  <= 1'b0;
        o_rollover    <= 1'b0;
        o_timer_rst_n <= 1'b0;
        o_timerenb    <= 1'b0;
        o_running     <= 1'b0;
      end else if (i_start_stop) begin
        case (state)
          IDLE, PAUSE: begin
            state      <= RUN;
            o_timerenb <= 1'b1;
            o_running  <= 1'b1;
          end
          RUN, LAP: begin
            state        <= PAUSE;
            o_timerenb   <= 1'b0;
            o_running    <= 1'b0;
            o_lap_active <= 1'b0;
          end
          default: ;
        endcase
      end else if (i_lap) begin
        if (state == RUN) begin
          state        <= LAP;
          lap_time     <= live_time;
          o_lap_active <= 1'b1;
        end else if (state == LAP) begin
          state        <= RUN;
          o_lap_active <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl : directed and random checks against a centisecond model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int MAX_MIN = 1;
  localparam int PERIOD  = (MAX_MIN + 1) * 6000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start_stop = 1'b0;
  logic       i_lap = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_base_tick = 1'b0;
  logic       o_timerenb, o_timer_rst_n, o_running, o_lap_active, o_rollover;
  logic [7:0] o_disp_cs, o_disp_sec, o_disp_min;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
    .i_sclk        (clk),
    .i_reset       (i_reset),
    .i_start_stop  (i_start_stop),
    .i_lap         (i_lap),
    .i_clear       (i_clear),
    .i_base_tick   (i_base_tick),
    .o_timerenb    (o_timerenb),
    .o_timer_rst_n (o_timer_rst_n),
    .o_running     (o_running),
    .o_lap_active  (o_lap_active),
    .o_disp_cs     (o_disp_cs),
    .o_disp_sec    (o_disp_sec),
    .o_disp_min    (o_disp_min),
    .o_rollover    (o_rollover)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: time kept as a plain count of centiseconds.
  int m_state = S_IDLE;
  int m_total = 0;
  int m_lap   = 0;
  int m_disp  = 0;
  bit m_tq = 0, m_lapact = 0, m_roll = 0, m_rstn = 0, m_enb = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [23:0] disp_of(input int t);
    return {bcd(t / 6000), bcd((t / 100) % 60), bcd(t % 100)};
  endfunction

  task automatic model_step(input bit rst, input bit ss, input bit lp, input bit cl);
    int old;
    bit tick;
    if (rst) begin
      m_state = S_IDLE; m_total = 0; m_lap = 0; m_disp = 0;
      m_tq = 0; m_lapact = 0; m_roll = 0; m_rstn = 0; m_enb = 0;
    end else begin
      old    = m_total;
      tick   = (i_base_tick != m_tq);
      m_disp = m_lapact ? m_lap : m_total;
      m_tq   = i_base_tick;
      m_rstn = 1;
      m_roll = 0;
      if ((m_state == S_RUN || m_state == S_LAP) && tick) begin
        m_total = (m_total + 1) % PERIOD;
        m_roll  = (m_total == 0);
      end
      if (cl) begin
        m_state = S_IDLE; m_total = 0; m_lapact = 0; m_roll = 0; m_rstn = 0;
      end else if (ss) begin
        if (m_state == S_IDLE || m_state == S_PAUSE) m_state = S_RUN;
        else begin m_state = S_PAUSE; m_lapact = 0; end
      end else if (lp) begin
        if (m_state == S_RUN) begin m_state = S_LAP; m_lap = old; m_lapact = 1; end
        else if (m_state == S_LAP) begin m_state = S_RUN; m_lapact = 0; end
      end
      m_enb = (m_state == S_RUN || m_state == S_LAP);
    end
  endtask

  function automatic logic [23:0] disp();
    return {o_disp_min, o_disp_sec, o_disp_cs};
  endfunction

  // One clock: drive inputs, emulate the timer below, compare at negedge.
  task automatic cycle(input bit rst, input bit ss, input bit lp, input bit cl, input bit tg);
    i_reset = rst; i_start_stop = ss; i_lap = lp; i_clear = cl;
    if (o_timer_rst_n === 1'b0) i_base_tick = 1'b0;
    else if (tg)                i_base_tick = ~i_base_tick;
    @(posedge clk);
    model_step(rst, ss, lp, cl);
    @(negedge clk);
    check("timerenb", 32'(o_timerenb),    32'(m_enb));
    check("rst_n",    32'(o_timer_rst_n), 32'(m_rstn));
    check("running",  32'(o_running),     32'(m_enb));
    check("lapact",   32'(o_lap_active),  32'(m_lapact));
    check("rollover", 32'(o_rollover),    32'(m_roll));
    check("display",  32'(disp()),        32'(disp_of(m_disp)));
  endtask

  task automatic run_edges(input int n);
    repeat (n) cycle(0, 0, 0, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic restart();
    cycle(0, 0, 0, 1, 0);
    idle(1);
    cycle(0, 1, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("reset_disp", 32'(disp()), 32'h0);
    check("reset_rstn", 32'(o_timer_rst_n), 32'h0);
    check("reset_enb",  32'(o_timerenb), 32'h0);

    cycle(0, 1, 0, 0, 0);
    check("enb_after_start", 32'(o_timerenb), 32'h1);
    run_edges(150);
    idle(1);
    check("disp_1_50", 32'(disp()), 32'h000150);
    check("running_1_50", 32'(o_running), 32'h1);

    restart();
    run_edges(5999);
    idle(1);
    check("disp_59_99", 32'(disp()), 32'h005999);
    run_edges(1);
    idle(1);
    check("disp_1_00_00", 32'(disp()), 32'h010000);
    run_edges(5999);
    idle(1);
    check("disp_1_59_99", 32'(disp()), 32'h015999);
    run_edges(1);
    check("roll_pulse", 32'(o_rollover), 32'h1);
    idle(1);
    check("roll_single", 32'(o_rollover), 32'h0);
    check("disp_wrapped", 32'(disp()), 32'h000000);

    restart();
    run_edges(327);
    cycle(0, 0, 1, 0, 0);
    run_edges(50);
    idle(1);
    check("lap_frozen", 32'(disp()), 32'h000327);
    check("lap_active", 32'(o_lap_active), 32'h1);
    cycle(0, 0, 1, 0, 0);
    idle(1);
    check("lap_released", 32'(disp()), 32'h000377);

    restart();
    run_edges(40);
    cycle(0, 1, 0, 0, 0);
    run_edges(20);
    idle(1);
    check("pause_hold", 32'(disp()), 32'h000040);
    check("pause_enb", 32'(o_timerenb), 32'h0);
    cycle(0, 1, 0, 0, 0);
    run_edges(10);
    idle(1);
    check("resume", 32'(disp()), 32'h000050);

    restart();
    run_edges(25);
    if (i_base_tick == 1'b0) run_edges(1);
    cycle(0, 1, 1, 1, 0);
    check("clear_rstn_low", 32'(o_timer_rst_n), 32'h0);
    idle(1);
    check("clear_rstn_high", 32'(o_timer_rst_n), 32'h1);
    idle(1);
    check("clear_disp", 32'(disp()), 32'h0);
    check("clear_idle", 32'(o_running), 32'h0);

    restart();
    run_edges(1234);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("mid_reset_disp", 32'(disp()), 32'h0);
    check("mid_reset_lap", 32'(o_lap_active), 32'h0);
    repeat (3) cycle(1, 1, 0, 0, 0);
    check("reset_held_run", 32'(o_running), 32'h0);
    idle(1);

    repeat (4000) begin
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the 10 ms base-tick timer for the stopwatch. Converts debounced button pulses (start/stop, lap, clear) into the timer enable and timer reset. Counts base-tick edges into a BCD MM:SS.cc time value and drives a display bus that can be frozen for lap times. Sits between the button debouncers and the timer below it, and the 7-segment display driver above it.

Parameters:
MAX_MIN, 59, highest minute value before wrap to 00:00.00 (legal range 1..99)

Ports:
i_sclk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start_stop  in  1  single-cycle debounced pulse; toggles run/stop
i_lap  in  1  single-cycle debounced pulse; freezes or unfreezes the display
i_clear  in  1  single-cycle debounced pulse; zeroes the time, returns to IDLE
i_base_tick  in  1  timer toggle output; each edge (rise or fall) = 10 ms
o_timerenb  out  1  timer count enable
o_timer_rst_n  out  1  active-low timer reset (timer reset is active-low)
o_running  out  1  high in RUN or LAP
o_lap_active  out  1  high while the display is frozen
o_disp_cs  out  8  display centiseconds, 2 BCD digits (00-99)
o_disp_sec  out  8  display seconds, 2 BCD digits (00-59)
o_disp_min  out  8  display minutes, 2 BCD digits (00-MAX_MIN)
o_rollover  out  1  one-cycle pulse when the time wraps MAX_MIN:59.99 -> 00:00.00

Behaviour:
- Everything is sampled on posedge i_sclk. i_reset has priority over all other inputs.
- Reset values:
  - state = IDLE.
  - All time and lap registers = 0.
  - o_timerenb = 0, o_timer_rst_n = 0, o_running = 0, o_lap_active = 0, o_rollover = 0.
  - Tick-edge register = 0.
- o_timer_rst_n:
  - Low during reset.
  - Low for exactly 1 cycle after each accepted clear.
  - High otherwise.
- States:
  - IDLE: time = 0, timer disabled.
  - RUN: counting, display shows live time.
  - LAP: counting, display frozen.
  - PAUSE: stopped, display shows live (stopped) time.
- Event priority when pulses coincide: clear > start_stop > lap. Only the highest-priority event is acted on that cycle.
- Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - RUN + lap -> LAP: snapshot live time into the lap registers on the same edge.
  - LAP + lap -> RUN.
  - LAP + start_stop -> PAUSE: display unfreezes.
  - Any state + clear -> IDLE: time = 0, lap flag = 0, timer reset pulse issued.
  - lap in IDLE or PAUSE is ignored. clear in IDLE still pulses o_timer_rst_n.
- o_timerenb = 1 exactly in RUN and LAP (registered, updated with the state).
  - In PAUSE the timer's internal count holds, so resume keeps sub-10 ms phase.
- Tick detection:
  - Tick edge register tq <= i_base_tick every cycle, in every state.
  - tick = (i_base_tick != tq).
  - Time increments only when tick = 1 and state is RUN or LAP.
  - The timer-reset-induced fall of i_base_tick lands in IDLE and is not counted.
- Increment latency: the time register updates on the same clock edge that sees tick, so it is visible 1 cycle after i_base_tick changes.
- BCD arithmetic: each digit 0-9.
  - cs 99 -> 00 with carry into sec.
  - sec 59 -> 00 with carry into min.
  - min MAX_MIN -> 00 with o_rollover = 1 for that one cycle. Counting continues.
- Display outputs are registered.
  - Display = lap registers when o_lap_active = 1, else live time.
  - A display update lags the live-time update by 1 cycle.
- start_stop and tick on the same cycle in RUN: the tick is counted, then the state moves to PAUSE.
- Mid-operation reset or clear: the current count is discarded. No rollover pulse is generated.

Decomposition:
- Package stopwatch_pkg holds:
  - State enum (IDLE, RUN, PAUSE, LAP).
  - BCD time struct {min, sec, cs}, each logic [7:0].
  - Constants CS_MAX = 8'h99, SEC_MAX = 8'h59.
- One sub-module: bcd_time_inc.
  - Inputs: time, en, max_min.
  - Outputs: next time, wrap flag.
  - Combinational 2-digit BCD cascade, reused by the display driver tests.

Test Plan:
- Reset then start_stop pulse, drive 150 base-tick edges -> o_timerenb = 1 one cycle after the pulse, display 00:01.50, o_running = 1.
- Preload run to 00:59.99, one more edge -> 01:00.00. At MAX_MIN = 1, 01:59.99 plus one edge -> 00:00.00 with a single-cycle o_rollover.
- Run to 00:03.27, lap, 50 more edges -> display holds 00:03.27 with o_lap_active = 1. Lap again -> display 00:03.77.
- Run to 00:00.40, start_stop, 20 edges while paused -> display stays 00:00.40 and o_timerenb = 0. start_stop again plus 10 edges -> 00:00.50.
- clear, start_stop and lap asserted in the same cycle during RUN -> IDLE, time 00:00.00, o_timer_rst_n low exactly 1 cycle, the falling edge of i_base_tick is not counted.
- i_reset asserted at 00:12.34 in LAP -> all outputs at reset values on the next edge. i_reset held with start_stop pulses -> stays IDLE.
